// File: rtl/idecode_regfile_pipe.sv
// Decode-stage register file: registered write-back stage with read bypass,
// a load scoreboard that stalls decode, and a saturating stall counter.

module idecode_regfile_rd_port #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic              stg_vld,
    input  logic [ADDR_W-1:0] stg_dest,
    input  logic [DATA_W-1:0] stg_data,
    input  logic [DATA_W-1:0] arr_data,
    output logic [DATA_W-1:0] rdata
);
    // The stage register holds the newest value for its dest, so it beats the array.
    always_comb begin
        rdata = arr_data;
        if (addr == '0)
            rdata = '0;
        else if (stg_vld && stg_dest == addr)
            rdata = stg_data;
    end
endmodule

module idecode_regfile_pipe #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int RESET_MODE = 1,
    parameter int CNT_W      = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [31:0]       instruction,
    input  logic              id_valid,
    input  logic              ld_issue,
    output logic [ADDR_W-1:0] read_register_1_address,
    output logic [DATA_W-1:0] read_data_1,
    output logic [DATA_W-1:0] read_data_2,
    output logic [DATA_W-1:0] sign_extend,
    output logic              stall,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_dest,
    input  logic [1:0]        wb_sel,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] mem_data,
    input  logic [DATA_W-1:0] link_pc,
    output logic [CNT_W-1:0]  stall_count
);
    localparam int NREGS     = 1 << ADDR_W;
    localparam int NUM_PORTS = 2;

    logic [5:0]        op;
    logic [15:0]       imm;
    logic [ADDR_W-1:0] rs, rt;

    assign op  = instruction[31:26];
    assign rs  = instruction[21 +: ADDR_W];
    assign rt  = instruction[16 +: ADDR_W];
    assign imm = instruction[15:0];
    assign read_register_1_address = rs;

    logic [DATA_W-1:0] regs [NREGS];
    logic              stg_vld;
    logic [ADDR_W-1:0] stg_dest;
    logic [DATA_W-1:0] stg_data;
    logic [NREGS-1:0]  busy, busy_nxt;

    // Immediate: logical ops and sltiu take the zero-extended form.
    logic zext;
    assign zext = op inside {6'b001100, 6'b001101, 6'b001110, 6'b001011};

    generate
        if (DATA_W > 16) begin : g_ext
            assign sign_extend = zext ? {{(DATA_W-16){1'b0}}, imm}
                                      : {{(DATA_W-16){imm[15]}}, imm};
        end else begin : g_trunc
            assign sign_extend = imm[DATA_W-1:0];
        end
    endgenerate

    logic [NUM_PORTS-1:0][ADDR_W-1:0] rd_addr;
    logic [NUM_PORTS-1:0][DATA_W-1:0] rd_arr, rd_data;

    assign rd_addr[0] = rs;
    assign rd_addr[1] = rt;

    generate
        for (genvar p = 0; p < NUM_PORTS; p++) begin : g_rd
            assign rd_arr[p] = regs[rd_addr[p]];
            idecode_regfile_rd_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd (
                .addr     (rd_addr[p]),
                .stg_vld  (stg_vld),
                .stg_dest (stg_dest),
                .stg_data (stg_data),
                .arr_data (rd_arr[p]),
                .rdata    (rd_data[p])
            );
        end
    endgenerate

    assign read_data_1 = rd_data[0];
    assign read_data_2 = rd_data[1];

    logic [DATA_W-1:0] wb_data;
    logic              cap, ld_set, ld_clr;

    always_comb begin
        case (wb_sel)
            2'b01:   wb_data = mem_data;
            2'b10:   wb_data = link_pc;
            default: wb_data = alu_result;
        endcase
    end

    assign cap    = wb_valid && wb_sel != 2'b11 && wb_dest != '0;
    assign ld_clr = cap && wb_sel == 2'b01;
    assign ld_set = id_valid && ld_issue && !stall && rt != '0;
    assign stall  = id_valid && (busy[rs] || busy[rt]);

    // Set is applied after clear: a newer load to the same register stays outstanding.
    always_comb begin
        busy_nxt = busy;
        if (ld_clr) busy_nxt[wb_dest] = 1'b0;
        if (ld_set) busy_nxt[rt] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stg_vld     <= 1'b0;
            stg_dest    <= '0;
            stg_data    <= '0;
            busy        <= '0;
            stall_count <= '0;
            for (int i = 0; i < NREGS; i++)
                regs[i] <= (RESET_MODE != 0) ? DATA_W'(i) : '0;
        end else begin
            stg_vld <= cap;
            if (cap) begin
                stg_dest <= wb_dest;
                stg_data <= wb_data;
            end
            if (stg_vld && stg_dest != '0)
                regs[stg_dest] <= stg_data;
            busy <= busy_nxt;
            if (stall && stall_count != '1)
                stall_count <= stall_count + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_idecode_regfile_pipe.sv
// Directed bench: stimulus pushes expected outputs into a queue, a negedge
// monitor drains and compares them against two DUT configurations.

module tb_idecode_regfile_pipe;
    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] instruction;
    logic        id_valid, ld_issue;
    logic        wb_valid;
    logic [4:0]  wb_dest;
    logic [1:0]  wb_sel;
    logic [31:0] alu_result, mem_data, link_pc;

    logic [4:0]  rs_a, rs_b;
    logic [31:0] rd1_a, rd2_a, sext_a, rd1_b, rd2_b, sext_b;
    logic        stall_a, stall_b;
    logic [15:0] cnt_a;
    logic [1:0]  cnt_b;

    always #5 clock = ~clock;

    idecode_regfile_pipe #(.DATA_W(32), .ADDR_W(5), .RESET_MODE(1), .CNT_W(16)) dut_a (
        .clock(clock), .reset(reset), .instruction(instruction), .id_valid(id_valid),
        .ld_issue(ld_issue), .read_register_1_address(rs_a), .read_data_1(rd1_a),
        .read_data_2(rd2_a), .sign_extend(sext_a), .stall(stall_a), .wb_valid(wb_valid),
        .wb_dest(wb_dest), .wb_sel(wb_sel), .alu_result(alu_result), .mem_data(mem_data),
        .link_pc(link_pc), .stall_count(cnt_a)
    );

    idecode_regfile_pipe #(.DATA_W(32), .ADDR_W(5), .RESET_MODE(0), .CNT_W(2)) dut_b (
        .clock(clock), .reset(reset), .instruction(instruction), .id_valid(id_valid),
        .ld_issue(ld_issue), .read_register_1_address(rs_b), .read_data_1(rd1_b),
        .read_data_2(rd2_b), .sign_extend(sext_b), .stall(stall_b), .wb_valid(wb_valid),
        .wb_dest(wb_dest), .wb_sel(wb_sel), .alu_result(alu_result), .mem_data(mem_data),
        .link_pc(link_pc), .stall_count(cnt_b)
    );

    localparam int RD1A = 0, RD2A = 1, SEXT = 2, STLA = 3, CNTA = 4;
    localparam int RD1B = 5, RD2B = 6, STLB = 7, CNTB = 8, RSADR = 9, SEXB = 10;

    typedef struct {
        string       name;
        int          sig;
        logic [31:0] exp;
    } chk_t;

    chk_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic logic [31:0] probe(input int s);
        case (s)
            RD1A:    return rd1_a;
            RD2A:    return rd2_a;
            SEXT:    return sext_a;
            STLA:    return {31'd0, stall_a};
            CNTA:    return {16'd0, cnt_a};
            RD1B:    return rd1_b;
            RD2B:    return rd2_b;
            STLB:    return {31'd0, stall_b};
            CNTB:    return {30'd0, cnt_b};
            RSADR:   return {27'd0, rs_a};
            SEXB:    return sext_b;
            default: return 32'hxxxx_xxxx;
        endcase
    endfunction

    task automatic expect_v(input string n, input int s, input logic [31:0] e);
        chk_t c;
        c.name = n;
        c.sig  = s;
        c.exp  = e;
        q.push_back(c);
    endtask

    chk_t        mc;
    logic [31:0] mact;
    always @(negedge clock) begin
        while (q.size() > 0) begin
            mc   = q.pop_front();
            mact = probe(mc.sig);
            n_checks++;
            if (mact !== mc.exp) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", mc.name, mact, mc.exp);
            end
        end
    end

    function automatic logic [31:0] ins(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wb(input logic v, input logic [4:0] d, input logic [1:0] s,
                      input logic [31:0] val);
        wb_valid   = v;
        wb_dest    = d;
        wb_sel     = s;
        alu_result = (s == 2'b00) ? val : 32'h0BAD_0003;
        mem_data   = (s == 2'b01) ? val : 32'h0BAD_0001;
        link_pc    = (s == 2'b10) ? val : 32'h0BAD_0002;
    endtask

    initial begin
        reset = 1'b1; instruction = '0; id_valid = 1'b0; ld_issue = 1'b0;
        wb(1'b0, 5'd0, 2'b00, 32'h0);
        tick(); tick();
        reset = 1'b0;

        // Reset contents
        instruction = ins(6'd0, 5'd5, 5'd7, 16'h0); id_valid = 1'b1;
        expect_v("rst_rd1_a", RD1A, 32'd5);
        expect_v("rst_rd2_a", RD2A, 32'd7);
        expect_v("rst_stall", STLA, 32'd0);
        expect_v("rst_cnt",   CNTA, 32'd0);
        expect_v("rst_rd1_b", RD1B, 32'd0);
        expect_v("rst_rd2_b", RD2B, 32'd0);
        expect_v("rs_addr",   RSADR, 32'd5);
        tick();

        // ALU write-back to 9: bypass then committed value
        instruction = ins(6'd0, 5'd9, 5'd0, 16'h0);
        wb(1'b1, 5'd9, 2'b00, 32'hDEAD_BEEF);
        expect_v("pre_wb_rd1", RD1A, 32'd9);
        tick();
        wb(1'b0, 5'd0, 2'b00, 32'h0);
        expect_v("bypass_rd1_a", RD1A, 32'hDEAD_BEEF);
        expect_v("bypass_rd1_b", RD1B, 32'hDEAD_BEEF);
        tick();
        wb(1'b1, 5'd0, 2'b00, 32'h0000_1234);
        expect_v("commit_rd1", RD1A, 32'hDEAD_BEEF);
        tick();
        wb(1'b0, 5'd0, 2'b00, 32'h0);
        instruction = ins(6'd0, 5'd0, 5'd9, 16'h0);
        expect_v("r0_rd1", RD1A, 32'd0);
        expect_v("r9_rd2", RD2A, 32'hDEAD_BEEF);
        tick();
        expect_v("r0_after", RD1A, 32'd0);
        tick();

        // Back-to-back write-backs to 4
        instruction = ins(6'd0, 5'd4, 5'd0, 16'h0);
        wb(1'b1, 5'd4, 2'b00, 32'h11);
        expect_v("r4_reset", RD1A, 32'd4);
        tick();
        wb(1'b1, 5'd4, 2'b00, 32'h22);
        expect_v("r4_first", RD1A, 32'h11);
        tick();
        wb(1'b0, 5'd0, 2'b00, 32'h0);
        expect_v("r4_second", RD1A, 32'h22);
        expect_v("r4_second_b", RD1B, 32'h22);
        tick();
        expect_v("r4_commit", RD1A, 32'h22);
        tick();

        // Load to 3, dependent instruction stalls 3 cycles
        instruction = ins(6'd0, 5'd0, 5'd3, 16'h0); ld_issue = 1'b1;
        expect_v("ld_issue_nostall", STLA, 32'd0);
        tick();
        ld_issue = 1'b0;
        instruction = ins(6'd0, 5'd3, 5'd0, 16'h0);
        expect_v("stall_c1", STLA, 32'd1);
        tick();
        expect_v("stall_c2", STLA, 32'd1);
        expect_v("cnt_c2",   CNTA, 32'd1);
        tick();
        expect_v("stall_c3", STLA, 32'd1);
        wb(1'b1, 5'd3, 2'b01, 32'h0000_CAFE);
        tick();
        wb(1'b0, 5'd0, 2'b00, 32'h0);
        expect_v("ld_done_stall", STLA, 32'd0);
        expect_v("ld_done_rd1",   RD1A, 32'h0000_CAFE);
        expect_v("cnt_3",         CNTA, 32'd3);
        expect_v("cnt_b_3",       CNTB, 32'd3);
        tick();

        // Same-edge clear and set on 6: set wins
        instruction = ins(6'd0, 5'd0, 5'd6, 16'h0); ld_issue = 1'b1;
        wb(1'b1, 5'd6, 2'b01, 32'h66);
        expect_v("r6_nostall", STLA, 32'd0);
        tick();
        ld_issue = 1'b0;
        wb(1'b0, 5'd0, 2'b00, 32'h0);
        instruction = ins(6'd0, 5'd6, 5'd0, 16'h0);
        expect_v("r6_stall", STLA, 32'd1);
        expect_v("r6_stall_b", STLB, 32'd1);
        tick();
        expect_v("r6_stall2", STLA, 32'd1);
        tick();
        expect_v("r6_stall3", STLA, 32'd1);
        tick();
        expect_v("cnt_a_6",   CNTA, 32'd6);
        expect_v("cnt_b_sat", CNTB, 32'd3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        expect_v("rst_mid_stall", STLA, 32'd0);
        expect_v("rst_mid_cnt",   CNTA, 32'd0);
        expect_v("rst_mid_rd1",   RD1A, 32'd6);
        tick();

        // Immediates and jal link write-back
        id_valid = 1'b0;
        instruction = ins(6'b001101, 5'd0, 5'd0, 16'h8001);
        wb(1'b1, 5'd31, 2'b10, 32'h0000_0404);
        expect_v("ori_zext", SEXT, 32'h0000_8001);
        tick();
        wb(1'b0, 5'd0, 2'b00, 32'h0);
        instruction = ins(6'b001000, 5'd31, 5'd0, 16'h8001);
        expect_v("addi_sext",  SEXT, 32'hFFFF_8001);
        expect_v("addi_sext_b", SEXB, 32'hFFFF_8001);
        expect_v("jal_bypass", RD1A, 32'h0000_0404);
        tick();
        instruction = ins(6'b001011, 5'd31, 5'd0, 16'hF000);
        wb(1'b1, 5'd31, 2'b11, 32'h0BAD_0BAD);
        expect_v("sltiu_zext", SEXT, 32'h0000_F000);
        expect_v("jal_commit", RD1A, 32'h0000_0404);
        tick();
        wb(1'b0, 5'd0, 2'b00, 32'h0);
        expect_v("sel11_nop", RD1A, 32'h0000_0404);
        tick();
        expect_v("sel11_nop2", RD1A, 32'h0000_0404);
        tick();

        for (int i = 0; i < 10 && q.size() > 0; i++)
            @(negedge clock);
        #1;
        if (q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d pending, expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
